saradc_11b_dig_dither_ctrl: RTL

Conversion-level dither controller for the 11-bit SAR ADC digital core, sitting directly downstream of the 6-bit LFSR. At each conversion start it samples the LFSR value, drives it to the DAC dither capacitors, and pulses the LFSR advance enable. When the SAR loop finishes it subtracts the applied dither from the 12-bit raw code and saturates the difference to 11 bits. It also guards the conversion with a timeout.

---
 rtl/saradc_11b_dig_dither_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/saradc_11b_dig_dither_ctrl.sv
// saradc_11b_dig_dither_ctrl: per-conversion dither, correction and timeout.
// Optional feature macro: SARADC_11B_DITHER_EN (undefined = dither disabled).
module saradc_11b_dig_dither_ctrl (
    input  logic        clk,
    input  logic        res,
    input  logic        conv_start_i,
    input  logic [5:0]  lfsr_val_i,
    input  logic        sar_done_i,
    input  logic [11:0] sar_code_i,
    output logic        lfsr_enable_o,
    output logic [5:0]  dith_o,
    output logic        busy_o,
    output logic [10:0] result_o,
    output logic        result_valid_o,
    output logic        clip_o,
    output logic        err_timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        CORR = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  tmo_cnt_q, tmo_cnt_d;
    logic [11:0] raw_q, raw_d;
    logic [5:0]  dith_q, dith_d;
    logic        lfsr_en_q, lfsr_en_d;
    logic        busy_q, busy_d;
    logic [10:0] result_q, result_d;
    logic        valid_q, valid_d;
    logic        clip_q, clip_d;
    logic        tmo_err_q, tmo_err_d;

    logic [5:0]  dith_src;
    logic        lfsr_en_src;
    logic [12:0] diff;

`ifdef SARADC_11B_DITHER_EN
    assign dith_src    = lfsr_val_i;
    assign lfsr_en_src = 1'b1;
`else
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr_val_i;
    assign dith_src    = 6'd0;
    assign lfsr_en_src = 1'b0;
`endif

    // Signed correction: raw is at most 4095 and dither at most 63, so 13 bits suffice
    assign diff = {1'b0, raw_q} - {7'd0, dith_q};

    // Next-state and next-output computation for the conversion sequencer
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        raw_d     = raw_q;
        dith_d    = dith_q;
        lfsr_en_d = 1'b0;
        busy_d    = busy_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        clip_d    = 1'b0;
        tmo_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (conv_start_i) begin
                    dith_d    = dith_src;
                    lfsr_en_d = lfsr_en_src;
                    tmo_cnt_d = 6'd0;
                    busy_d    = 1'b1;
                    state_d   = CONV;
                end
            end
            CONV: begin
                if (sar_done_i) begin
                    raw_d   = sar_code_i;
                    state_d = CORR;
                end else if (tmo_cnt_q == 6'd63) begin
                    tmo_err_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 6'd1;
                end
            end
            CORR: begin
                if (diff[12]) begin
                    result_d = 11'd0;
                    clip_d   = 1'b1;
                end else if (diff[11]) begin
                    result_d = 11'd2047;
                    clip_d   = 1'b1;
                end else begin
                    result_d = diff[10:0];
                end
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset overriding everything
    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            tmo_cnt_q <= 6'd0;
            raw_q     <= 12'd0;
            dith_q    <= 6'd0;
            lfsr_en_q <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= 11'd0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            raw_q     <= raw_d;
            dith_q    <= dith_d;
            lfsr_en_q <= lfsr_en_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            clip_q    <= clip_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign lfsr_enable_o  = lfsr_en_q;
    assign dith_o         = dith_q;
    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign clip_o         = clip_q;
    assign err_timeout_o  = tmo_err_q;

endmodule
